booth_accum_ctrl: RTL and testbench

BOOTH_ACCUM_CTRL -- requirements
Module: booth_accum_ctrl

---
 rtl/booth_accum_ctrl.sv | 121 ++++++++++++
 tb/tb_booth_accum_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/booth_accum_ctrl.sv
// Radix-2 Booth multiply sequencer that drives an external Booth-table mux.
// Ports: clk, rst (sync, active-high), start/ready handshake, signed
// multiplicand/multiplier, booth_sel/seg0/seg1 to the mux, addend from the
// mux, registered signed product and a one-cycle done pulse.
module booth_accum_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic [1:0]           booth_sel,
    output logic [WIDTH-1:0]     seg0,
    output logic [WIDTH-1:0]     seg1,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     qr_q, qr_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic                 ext;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH+1:0]   shifted;

    // The mux only sees WIDTH bits; -M cannot represent +2^(WIDTH-1),
    // so the sign-extension bit is rebuilt here from M itself.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        qr_d      = qr_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        ready     = 1'b0;
        done      = 1'b0;
        booth_sel = 2'b00;
        ext       = 1'b0;
        sum       = a_q;
        shifted   = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    m_d     = multiplicand;
                    a_d     = '0;
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                booth_sel = {qr_q[0], q1_q};
                case (booth_sel)
                    2'b01:   ext = m_q[WIDTH-1];
                    2'b10:   ext = (m_q != '0) ? ~m_q[WIDTH-1] : 1'b0;
                    default: ext = 1'b0;
                endcase
                sum     = a_q + {ext, addend};
                // Arithmetic shift of {sum,Q,Q_1}: Q_1 falls off the end.
                shifted = {sum[WIDTH], sum, qr_q};
                a_d     = shifted[2*WIDTH+1:WIDTH+1];
                qr_d    = shifted[WIDTH:1];
                q1_d    = shifted[0];
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    prod_d  = {a_d[WIDTH-1:0], qr_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign seg0    = m_q;
    assign seg1    = -m_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_accum_ctrl.sv
// Scoreboard bench for booth_accum_ctrl with a behavioural Booth-table mux.
// Expected products are queued at acceptance and checked on each done pulse.
module tb_booth_accum_ctrl;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           ready;
    logic [1:0]     booth_sel;
    logic [W-1:0]   seg0;
    logic [W-1:0]   seg1;
    logic [W-1:0]   addend;
    logic [2*W-1:0] product;
    logic           done;

    booth_accum_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .ready(ready),
        .booth_sel(booth_sel),
        .seg0(seg0),
        .seg1(seg1),
        .addend(addend),
        .product(product),
        .done(done)
    );

    always #5 clk = ~clk;

    // Booth-table mux: 01 -> +M, 10 -> -M, otherwise zero.
    always_comb begin
        addend = '0;
        case (booth_sel)
            2'b01:   addend = seg0;
            2'b10:   addend = seg1;
            default: addend = '0;
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] sref(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic signed [2*W-1:0] r;
        r = (2*W)'(signed'(a)) * (2*W)'(signed'(b));
        return r;
    endfunction

    // Reference sequencing model driven only by bench inputs.
    int             mdl_cnt = 0;
    logic [W-1:0]   mdl_m = '0;
    logic           acc_now = 1'b0;
    logic           clr = 1'b0;
    logic [2*W-1:0] sb[$];

    always @(posedge clk) begin
        acc_now <= 1'b0;
        clr     <= 1'b0;
        if (rst) begin
            mdl_cnt <= 0;
            mdl_m   <= '0;
            sb.delete();
            clr     <= 1'b1;
        end else if (mdl_cnt == 0 && start) begin
            mdl_cnt <= W + 1;
            mdl_m   <= multiplicand;
            sb.push_back(sref(multiplicand, multiplier));
            acc_now <= 1'b1;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    logic [2*W-1:0] held = '0;
    logic [W-1:0]   neg_m;
    logic           zq = 1'b0;

    always @(negedge clk) begin
        if (clr) held = '0;
        neg_m = -mdl_m;
        chk("ready", ready, mdl_cnt == 0);
        chk("done", done, mdl_cnt == 1);
        chk("seg0", seg0, mdl_m);
        chk("seg1", seg1, neg_m);
        if (mdl_cnt <= 1) chk("sel_idle", booth_sel, 2'b00);
        if (zq && mdl_cnt >= 2) chk("sel_zq", booth_sel, 2'b00);
        if (done) begin
            chk("sb_depth", sb.size() > 0, 1'b1);
            if (sb.size() > 0) held = sb.pop_front();
        end
        chk("product", product, held);
    end

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    logic ok;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        go(16'd3, 16'd5);            repeat (20) @(posedge clk);
        go(16'hFFF9, 16'd3);         repeat (20) @(posedge clk);
        go(16'h8000, 16'h8000);      repeat (20) @(posedge clk);
        go(16'h8000, 16'd1);         repeat (20) @(posedge clk);
        go(16'h7FFF, 16'h8000);      repeat (20) @(posedge clk);
        zq = 1'b1;
        go(16'h1234, 16'd0);         repeat (20) @(posedge clk);
        zq = 1'b0;
        go(16'd0, 16'h7FFF);         repeat (20) @(posedge clk);

        // starts during RUN and during DONE must be ignored
        go(16'd2, 16'd3);
        repeat (4) @(posedge clk); #1;
        multiplicand = 16'd100; multiplier = 16'd100; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (11) @(posedge clk); #1;
        multiplicand = 16'd7; multiplier = 16'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);

        // reset in the middle of RUN aborts, then a normal run
        go(16'd9, 16'd9);
        repeat (8) @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        go(16'hFFFF, 16'hFFFF);      repeat (20) @(posedge clk);

        // back-to-back with start held high
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (acc_now) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("accept", ok, 1'b1);
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
        end
        start = 1'b0;

        for (int k = 0; k < 100; k++) begin
            if (mdl_cnt == 0 && sb.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        chk("drain", (mdl_cnt == 0) && (sb.size() == 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
